// File: rtl/mem_access_responder.sv
// Memory-side responder for the active-low Flash/SRAM control bus: two on-chip word
// arrays answered after a fixed number of wait states with a one-cycle ready pulse.
module mem_access_responder #(
  parameter int N           = 32,
  parameter int DATA_W      = 32,
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_STATES = 2
) (
  input  logic              clk,
  input  logic              nRESET,
  input  logic              CE,
  input  logic              OE,
  input  logic              WE,
  input  logic              WP,
  input  logic [N-1:0]      address,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic [1:0]        err,
  output logic              busy
);

  localparam logic [N-1:0] FLASH_LAST = N'(32'h0FFF_FFFF);
  localparam logic [N-1:0] SRAM_BASE  = N'(32'h1000_0000);
  localparam logic [N-1:0] SRAM_LAST  = N'(32'h44E1_1FFF);
  localparam logic [3:0]   WAIT_LOAD  = 4'(WAIT_STATES);

  localparam logic [1:0] ERR_OK     = 2'b00;
  localparam logic [1:0] ERR_DECODE = 2'b01;
  localparam logic [1:0] ERR_WPROT  = 2'b10;
  localparam logic [1:0] ERR_CONT   = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_HOLD} state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic [N-1:0]        addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                oe_q;
  logic                we_q;
  logic                wp_q;

  logic [DATA_W-1:0]   flash_mem [0:(1<<DEPTH_LOG2)-1];
  logic [DATA_W-1:0]   sram_mem  [0:(1<<DEPTH_LOG2)-1];

  logic                is_flash;
  logic                is_sram;
  logic [DEPTH_LOG2-1:0] flash_idx;
  logic [DEPTH_LOG2-1:0] sram_idx;
  logic [1:0]          resp_err;
  logic                mem_wr;

  assign is_flash  = (addr_q <= FLASH_LAST);
  assign is_sram   = (addr_q >= SRAM_BASE) && (addr_q <= SRAM_LAST);
  assign flash_idx = addr_q[DEPTH_LOG2+1:2];
  assign sram_idx  = DEPTH_LOG2'((addr_q - SRAM_BASE) >> 2);

  // Completion status of the latched access, contention first, then decode, then protect.
  always_comb begin
    resp_err = ERR_OK;
    if (!oe_q && !we_q)
      resp_err = ERR_CONT;
    else if (!is_flash && !is_sram)
      resp_err = ERR_DECODE;
    else if (!we_q && is_flash && !wp_q)
      resp_err = ERR_WPROT;
  end

  assign mem_wr = (state == S_RESP) && (resp_err == ERR_OK) && !we_q;

  // Arrays carry no reset so that they map onto plain block RAM.
  always_ff @(posedge clk) begin
    if (mem_wr) begin
      if (is_flash)
        flash_mem[flash_idx] <= wdata_q;
      else
        sram_mem[sram_idx] <= wdata_q;
    end
  end

  always_ff @(posedge clk or negedge nRESET) begin
    if (!nRESET) begin
      state   <= S_IDLE;
      cnt     <= 4'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      oe_q    <= 1'b1;
      we_q    <= 1'b1;
      wp_q    <= 1'b1;
      rdata   <= '0;
      ready   <= 1'b0;
      err     <= ERR_OK;
      busy    <= 1'b0;
    end else begin
      ready <= 1'b0;
      err   <= ERR_OK;
      case (state)
        S_IDLE: begin
          if (!CE && !(OE && WE)) begin
            addr_q  <= address;
            wdata_q <= wdata;
            oe_q    <= OE;
            we_q    <= WE;
            wp_q    <= WP;
            cnt     <= WAIT_LOAD;
            busy    <= 1'b1;
            state   <= (WAIT_STATES == 0) ? S_RESP : S_WAIT;
          end
        end
        S_WAIT: begin
          if (CE) begin
            cnt   <= 4'd0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end else if (cnt == 4'd1) begin
            cnt   <= 4'd0;
            state <= S_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        // The ready pulse is raised on the edge leaving RESP, so it lines up with HOLD.
        S_RESP: begin
          ready <= 1'b1;
          err   <= resp_err;
          if (resp_err == ERR_OK && !oe_q)
            rdata <= is_flash ? flash_mem[flash_idx] : sram_mem[sram_idx];
          state <= S_HOLD;
        end
        S_HOLD: begin
          if (CE) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_responder.md
# mem_access_responder

- Memory-side responder for the active-low Flash/SRAM control bus (CE, OE, WE, WP plus 32-bit address) produced by the system address decoder.
- Contains two word-addressed on-chip arrays: a Flash image and an SRAM image.
- Completes each access after a programmable number of wait states, then returns a one-cycle ready pulse with read data or an error code.
- Serves as the bench and FPGA stand-in for external memories.

## Interface

- N, 32, address width
- DATA_W, 32, data word width
- DEPTH_LOG2, 8, log2 of words per array; word index = address[DEPTH_LOG2+1:2]
- WAIT_STATES, 2, wait cycles inserted before response (0..15)

- clk  in  1  system clock, rising edge
- nRESET  in  1  asynchronous, active-low reset
- CE  in  1  chip enable, active low
- OE  in  1  output (read) enable, active low
- WE  in  1  write enable, active low
- WP  in  1  write protect, active low; applies to the Flash region only
- address  in  N  byte address
- wdata  in  DATA_W  write data
- rdata  out  DATA_W  read data, registered
- ready  out  1  one-cycle completion pulse
- err  out  2  completion status: 00 ok, 01 decode error, 10 write-protect violation, 11 contention; valid only with ready
- busy  out  1  high from access capture until return to IDLE

## Operation

**Regions**
- Flash: 0x0000_0000..0x0FFF_FFFF.
- SRAM: 0x1000_0000..0x44E1_1FFF.
- Any other address is a decode error.
- Byte offset address[1:0] is ignored.

**States:** IDLE, WAIT, RESP, HOLD.

**IDLE**
- Stays in IDLE while CE=1.
- Also stays in IDLE when CE=0 with OE=1 and WE=1; this is a no-op with no ready.
- Otherwise, at the capturing edge, latches address, wdata, OE, WE and WP.
- Loads wait counter with WAIT_STATES.
- Moves to WAIT, or directly to RESP if WAIT_STATES=0.

**WAIT**
- Counter decrements each cycle; goes to RESP when counter reaches 1.
- CE=1 sampled in WAIT aborts the access: return to IDLE, no write, no ready, rdata unchanged.

**RESP** (one cycle; ready=1)
- Error priority: contention (latched OE=0 and WE=0) > decode > write-protect.
- Write (WE=0, OE=1):
  - Flash with latched WP=0 gives err=10 and no write.
  - Otherwise the selected array word is written and err=00.
- Read (OE=0, WE=1): rdata is loaded from the selected array and err=00.
- On any error: no array write, rdata unchanged.

**HOLD**
- Waits for CE=1, then returns to IDLE.
- A new access requires CE to deassert and then reassert.

**Other rules**
- Inputs other than CE are ignored after capture.
- Array contents are not reset.
- Flash and SRAM arrays are independent; SRAM offset is (address − 0x1000_0000).

## Timing

**Reset values:** rdata=0, ready=0, err=00, busy=0, state IDLE, wait counter=0.

**Reset mid-access:** asynchronous return to reset values; any pending write is discarded.

**Latency**
- The capturing edge is edge k.
- ready is high in the cycle after edge k+WAIT_STATES+1, for exactly one cycle.
- With WAIT_STATES=0, ready follows the capture edge by one edge.

**Outputs**
- rdata updates on the same edge that raises ready and holds until the next successful read.
- err is driven together with ready and returns to 00 when ready drops.
- busy rises on the capturing edge and falls on the edge entering IDLE.

**Back-to-back and boundary cases**
- Minimum spacing between two accesses is WAIT_STATES+3 cycles: capture, waits, RESP, HOLD exit with CE high.
- CE held low continuously after RESP never starts a second access.
- Abort: CE=1 sampled in the last WAIT cycle still aborts; RESP is never partially executed.
- Address boundaries are inclusive: 0x0FFF_FFFF is Flash, 0x1000_0000 is SRAM, 0x44E1_1FFF is SRAM, 0x44E1_2000 is a decode error.

## Test plan

1. **SRAM write then read** (WAIT_STATES=2)
   - Stimulus: write 0xDEAD_BEEF to 0x1000_0010 with WE=0, OE=1; then read with OE=0, WE=1.
   - Required: ready 3 cycles after each capture, err=00, rdata=0xDEAD_BEEF.
2. **Flash write protect**
   - Stimulus: write 0x1234_5678 to 0x0000_0020 with WP=1, read back; then write 0xAAAA_AAAA with WP=0 and read again.
   - Required: first write err=00 and readback 0x1234_5678; second write err=10; readback still 0x1234_5678.
3. **Decode boundary**
   - Stimulus: read 0x44E1_1FFC, then read 0x44E1_2000.
   - Required: first err=00; second err=01 with rdata unchanged.
4. **Contention and no-op**
   - Stimulus: CE=0 with OE=0 and WE=0 at 0x1000_0000; then CE=0 with OE=1 and WE=1.
   - Required: first gives err=11 with no write; second gives no ready and busy stays 0.
5. **Abort**
   - Stimulus: start an SRAM write of 0x5555_5555, raise CE during WAIT, then read the same address.
   - Required: no ready for the aborted access; read returns the prior contents.
6. **Reset mid-access and zero wait**
   - Stimulus: assert nRESET=0 during WAIT; then, with WAIT_STATES=0, run a single read.
   - Required: outputs go to reset values immediately on reset; afterwards ready follows capture by exactly one edge.
